mips_branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. Replaces the single-cycle, compare-only taken decision in ID.
- Direct-mapped branch target buffer (BTB) with per-entry saturating counters.
- Looked up combinationally by IF with the current PC. Trained by ID/EX once the branch or jump outcome resolves.
- Keeps a saturating misprediction counter for performance runs.

---
 rtl/mips_bp_pkg.sv | 38 +++
 rtl/mips_sat_counter.sv | 41 ++++
 rtl/mips_branch_predictor.sv | 127 ++++++++++++
 tb/tb_mips_branch_predictor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bp_pkg.sv
// Shared types and helpers for the MIPS dynamic branch predictor.
// BTB entry layout, counter reset/allocation constants, PC index/tag slicing.
// Entry fields are sized for the widest build; upper bits stay zero when narrower.
package mips_bp_pkg;

  localparam int BP_MAX_ADDR_W = 64;
  localparam int BP_MAX_TAG_W  = 32;

  typedef struct packed {
    logic                     valid;
    logic [BP_MAX_TAG_W-1:0]  tag;
    logic [BP_MAX_ADDR_W-1:0] target;
  } bp_entry_t;

  // Weakly-not-taken reset value: 2^(w-1)-1 (0 for a 1-bit counter).
  function automatic int unsigned bp_ctr_init(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Weakly-taken value loaded on allocation: 2^(w-1).
  function automatic int unsigned bp_ctr_alloc(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // BTB index: word-address bits just above the byte offset.
  function automatic logic [BP_MAX_ADDR_W-1:0] bp_index(input logic [BP_MAX_ADDR_W-1:0] pc,
                                                        input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // BTB tag: the TAG_W bits directly above the index field.
  function automatic logic [BP_MAX_ADDR_W-1:0] bp_tag(input logic [BP_MAX_ADDR_W-1:0] pc,
                                                      input int unsigned idx_w,
                                                      input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Up/down saturating counter with synchronous load and parameterised reset value.
// Latency: count_o reflects inc/dec/load one clock after they are presented.
// No backpressure; load wins over inc/dec, simultaneous inc and dec hold.
module mips_sat_counter
  import mips_bp_pkg::*;
#(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next value: load, else step toward the rail without wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && !dec_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter state, asynchronously forced to its reset value.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) count_q <= RST_VAL;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB predictor with per-entry saturating counters and a mispredict counter.
// Latency: lookup is combinational (0 cycles); updates are visible the cycle after the edge.
// No backpressure; one update per cycle is always accepted. Optional MIPS_BP_GSHARE_EN adds a GHR.
module mips_branch_predictor
  import mips_bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 6,
  parameter int PERF_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_mispredict,
  output logic [PERF_W-1:0] mispredict_count
);

  localparam int           IDX_W     = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'(bp_ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(bp_ctr_alloc(CTR_W));

  bp_entry_t               ent_q [ENTRIES];
  bp_entry_t               ent_d;
  logic [CTR_W-1:0]        ctr   [ENTRIES];
  logic [IDX_W-1:0]        lk_idx, up_idx, lk_cidx, up_cidx;
  logic [TAG_W-1:0]        lk_tag, up_tag;
  logic                    ent_we, up_hit, alloc;
  logic [BP_MAX_ADDR_W-1:0] rd_target;
  logic                    unused_rd;

  assign lk_idx = IDX_W'(bp_index(BP_MAX_ADDR_W'(lookup_pc), IDX_W));
  assign lk_tag = TAG_W'(bp_tag(BP_MAX_ADDR_W'(lookup_pc), IDX_W, TAG_W));
  assign up_idx = IDX_W'(bp_index(BP_MAX_ADDR_W'(update_pc), IDX_W));
  assign up_tag = TAG_W'(bp_tag(BP_MAX_ADDR_W'(update_pc), IDX_W, TAG_W));

`ifdef MIPS_BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // History shifts in every resolved outcome, newest in bit 0.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid) ghr_d = HIST_W'({ghr_q, update_taken});
  end

  // Global history register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  // Counters are hashed with history; tag/target stay on the plain index.
  assign lk_cidx   = lk_idx ^ IDX_W'(ghr_q);
  assign up_cidx   = up_idx ^ IDX_W'(update_hist);
  assign pred_hist = ghr_q;
`else
  logic unused_hist;
  assign lk_cidx     = lk_idx;
  assign up_cidx     = up_idx;
  assign pred_hist   = '0;
  assign unused_hist = ^update_hist;
`endif

  // Lookup reads pre-update state; a same-cycle write shows up next cycle.
  assign rd_target   = ent_q[lk_idx].target;
  assign unused_rd   = ^rd_target;
  assign pred_hit    = ent_q[lk_idx].valid && (ent_q[lk_idx].tag == BP_MAX_TAG_W'(lk_tag));
  assign pred_taken  = pred_hit && ctr[lk_cidx][CTR_W-1];
  assign pred_target = pred_taken ? rd_target[ADDR_W-1:0] : lookup_pc + ADDR_W'(4);

  // Every write path is qualified by update_valid so junk on idle update ports is harmless.
  assign up_hit = update_valid && ent_q[up_idx].valid &&
                  (ent_q[up_idx].tag == BP_MAX_TAG_W'(up_tag));
  assign alloc  = update_valid && !up_hit && update_taken;
  assign ent_we = update_valid && update_taken;

  // Taken hit and allocation both leave {valid, tag, target} = {1, tag, update_target}.
  always_comb begin
    ent_d        = '0;
    ent_d.valid  = 1'b1;
    ent_d.tag    = BP_MAX_TAG_W'(up_tag);
    ent_d.target = BP_MAX_ADDR_W'(update_target);
  end

  // BTB entry array; allocation silently evicts the previous occupant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
    end else if (ent_we) begin
      ent_q[up_idx] <= ent_d;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    mips_sat_counter #(.W(CTR_W), .RST_VAL(CTR_INIT)) u_ctr (
      .clock_i    (clock),
      .reset_i    (reset),
      .load_i     (alloc && (up_cidx == IDX_W'(g))),
      .load_val_i (CTR_ALLOC),
      .inc_i      (up_hit && update_taken && (up_cidx == IDX_W'(g))),
      .dec_i      (up_hit && !update_taken && (up_cidx == IDX_W'(g))),
      .count_o    (ctr[g])
    );
  end

  mips_sat_counter #(.W(PERF_W), .RST_VAL('0)) u_perf (
    .clock_i    (clock),
    .reset_i    (reset),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (update_valid && update_mispredict),
    .dec_i      (1'b0),
    .count_o    (mispredict_count)
  );

endmodule

// File: tb/tb_mips_branch_predictor.sv
module tb_mips_branch_predictor;

  localparam int ADDR_W = 32, ENTRIES = 64, TAG_W = 8, CTR_W = 2, HIST_W = 6, PERF_W = 4;
  localparam int CTR_MAX = 3, CTR_WEAK_T = 2, CTR_WEAK_N = 1, PERF_MAX = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] lookup_pc = '0;
  logic              pred_hit, pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [HIST_W-1:0] pred_hist;
  logic              update_valid = 1'b0;
  logic [ADDR_W-1:0] update_pc = '0;
  logic              update_taken = 1'b0;
  logic [ADDR_W-1:0] update_target = '0;
  logic [HIST_W-1:0] update_hist = '0;
  logic              update_mispredict = 1'b0;
  logic [PERF_W-1:0] mispredict_count;

  mips_branch_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W),
    .CTR_W(CTR_W), .HIST_W(HIST_W), .PERF_W(PERF_W)
  ) dut (
    .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_hist(pred_hist), .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_hist(update_hist), .update_mispredict(update_mispredict),
    .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the BTB should hold, in plain arithmetic.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_perf;
  int unsigned m_ghr;

  // Values sampled by the most recent step, for directed checks.
  logic        s_hit, s_taken;
  logic [31:0] s_target;
  logic [31:0] s_count;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % 256;
  endfunction

  function automatic int unsigned f_cidx(input int unsigned idx, input int unsigned hist);
`ifdef MIPS_BP_GSHARE_EN
    return idx ^ (hist % 64);
`else
    return idx + 0 * hist;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = CTR_WEAK_N;
    end
    m_perf = 0;
    m_ghr  = 0;
  endtask

  task automatic model_update();
    int unsigned i, ci;
    bit hit;
    if (!update_valid) return;
    i   = f_idx(update_pc);
    ci  = f_cidx(i, update_hist);
    hit = m_valid[i] && (m_tag[i] == f_tag(update_pc));
    if (hit) begin
      if (update_taken) begin
        if (m_ctr[ci] < CTR_MAX) m_ctr[ci]++;
        m_tgt[i] = update_target;
      end else if (m_ctr[ci] > 0) begin
        m_ctr[ci]--;
      end
    end else if (update_taken) begin
      m_valid[i] = 1; m_tag[i] = f_tag(update_pc); m_tgt[i] = update_target;
      m_ctr[ci] = CTR_WEAK_T;
    end
    if (update_mispredict && m_perf < PERF_MAX) m_perf++;
`ifdef MIPS_BP_GSHARE_EN
    m_ghr = ((m_ghr * 2) + (update_taken ? 1 : 0)) % 64;
`endif
  endtask

  task automatic check_outputs();
    int unsigned i, ci;
    bit          e_hit, e_taken;
    logic [31:0] e_tgt;
    i       = f_idx(lookup_pc);
    ci      = f_cidx(i, m_ghr);
    e_hit   = m_valid[i] && (m_tag[i] == f_tag(lookup_pc));
    e_taken = e_hit && (m_ctr[ci] >= CTR_WEAK_T);
    e_tgt   = e_taken ? m_tgt[i] : lookup_pc + 32'd4;
    chk("pred_hit", {63'd0, pred_hit}, {63'd0, e_hit});
    chk("pred_taken", {63'd0, pred_taken}, {63'd0, e_taken});
    chk("pred_target", {32'd0, pred_target}, {32'd0, e_tgt});
    chk("pred_hist", {58'd0, pred_hist}, 64'(m_ghr));
    chk("mispredict_count", {60'd0, mispredict_count}, 64'(m_perf));
    s_hit = pred_hit; s_taken = pred_taken; s_target = pred_target;
    s_count = 32'(mispredict_count);
  endtask

  // One cycle: drive after the edge, check at the falling edge, then advance the model.
  task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit umis);
    lookup_pc         = lpc;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_mispredict = umis;
    update_hist       = HIST_W'(m_ghr);
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    #1;
    model_update();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 2) << 8) | $urandom_range(0, 3);
    return pc;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state.
    step(32'h40, 0, 0, 0, 0, 0);
    chk("reset_hit", {63'd0, s_hit}, 64'd0);
    chk("reset_taken", {63'd0, s_taken}, 64'd0);
    chk("reset_target", {32'd0, s_target}, 64'h44);
    chk("reset_count", {32'd0, s_count}, 64'd0);

    // Allocate, then hit.
    step(32'h40, 1, 32'h40, 1, 32'h100, 1);
    step(32'h40, 0, 0, 0, 0, 0);
    chk("alloc_hit", {63'd0, s_hit}, 64'd1);
    chk("alloc_count", {32'd0, s_count}, 64'd1);

    // Counter walks down to 0, then up to saturation and holds.
    for (int k = 0; k < 2; k++) step(32'h40, 1, 32'h40, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) step(32'h40, 1, 32'h40, 1, 32'h100, 0);
    step(32'h40, 0, 0, 0, 0, 0);

    // Alias: same index, different tag, evicts the old occupant.
    step(32'h40, 1, 32'h40 + 4 * ENTRIES, 1, 32'h200, 0);
    step(32'h40, 0, 0, 0, 0, 0);
    chk("alias_old_hit", {63'd0, s_hit}, 64'd0);
    step(32'h40 + 4 * ENTRIES, 0, 0, 0, 0, 0);
    chk("alias_new_hit", {63'd0, s_hit}, 64'd1);

    // Same-cycle lookup and update: no bypass.
    step(32'h80, 1, 32'h80, 1, 32'h300, 0);
    chk("same_cycle_hit", {63'd0, s_hit}, 64'd0);
    step(32'h80, 0, 0, 0, 0, 0);
    chk("next_cycle_hit", {63'd0, s_hit}, 64'd1);

    // Reset asserted while an update is pending.
    lookup_pc = 32'hC0; update_valid = 1'b1; update_pc = 32'hC0;
    update_taken = 1'b1; update_target = 32'h400; update_mispredict = 1'b1;
    #2 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    step(32'hC0, 0, 0, 0, 0, 0);
    chk("reset_mid_update_hit", {63'd0, s_hit}, 64'd0);

    // Mispredict counter saturation.
    for (int k = 0; k < 20; k++) step(32'h44, 1, 32'h1000 + 32'(k * 4), 0, 0, 1);
    step(32'h44, 0, 0, 0, 0, 0);
    chk("perf_saturate", {32'd0, s_count}, 64'(PERF_MAX));

`ifdef MIPS_BP_GSHARE_EN
    reset = 1'b1;
    #3 reset = 1'b0;
    model_reset();
    step(32'h40, 1, 32'h40, 1, 32'h100, 0);
    step(32'h40, 1, 32'h40, 0, 32'h0, 0);
    step(32'h40, 1, 32'h40, 1, 32'h100, 0);
    step(32'h40, 0, 0, 0, 0, 0);
    chk("ghr_TNT", {58'd0, pred_hist}, 64'b000101);
`endif

    // Randomised traffic from a small PC pool so hits, aliases and saturation all occur.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7)
        step(rand_pc(), 1, rand_pc(), 1'($urandom_range(0, 1)),
             $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      else
        step(rand_pc(), 0, $urandom, 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
